// File: rtl/ocsim_source_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ocsim_source_arbiter_pkg
//   Shared definitions for the source arbiter slice: arbiter state encoding,
//   starvation slack used by the optional statistics block, and the helper
//   that sizes a requester index.
//
//   Contents:
//     ArbStarveSlack    extra cycles tolerated on top of Inputs*MaxBurst
//     arb_state_e       IDLE / LOCK arbiter states
//     SourceIndexWidth  index width for N requesters (minimum 1 bit)
// ----------------------------------------------------------------------------
package ocsim_source_arbiter_pkg;

    localparam int unsigned ArbStarveSlack = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int unsigned SourceIndexWidth(input int unsigned Inputs);
        return (Inputs > 1) ? $clog2(Inputs) : 1;
    endfunction

endpackage

// File: rtl/ocsim_source_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ocsim_rr_pick
//   Purely combinational round-robin picker. Scans the request vector starting
//   at i_ptr and wrapping modulo Inputs; the first asserted request wins.
//
//   Parameters:
//     Inputs       number of requesters (1..16)
//     SourceWidth  width of pointer / index
//   Ports:
//     i_req    [Inputs]       request vector
//     i_ptr    [SourceWidth]  index to start scanning from (must be < Inputs)
//     o_grant  [Inputs]       one-hot grant (all zero when nothing requests)
//     o_idx    [SourceWidth]  index of the granted requester
//     o_any    1              at least one request present
// ----------------------------------------------------------------------------
module ocsim_rr_pick
    import ocsim_source_arbiter_pkg::*;
#(
    parameter int unsigned Inputs      = 2,
    parameter int unsigned SourceWidth = SourceIndexWidth(Inputs)
) (
    input  logic [Inputs-1:0]      i_req,
    input  logic [SourceWidth-1:0] i_ptr,
    output logic [Inputs-1:0]      o_grant,
    output logic [SourceWidth-1:0] o_idx,
    output logic                   o_any
);

    // One extra bit so ptr+offset cannot overflow before the wrap subtract.
    logic [SourceWidth:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned i = 0; i < Inputs; i++) begin
            w_cand = {1'b0, i_ptr} + (SourceWidth+1)'(i);
            if (w_cand >= (SourceWidth+1)'(Inputs)) begin
                w_cand = w_cand - (SourceWidth+1)'(Inputs);
            end
            if (!o_any && i_req[w_cand[SourceWidth-1:0]]) begin
                o_any                              = 1'b1;
                o_idx                              = w_cand[SourceWidth-1:0];
                o_grant[w_cand[SourceWidth-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ocsim_source_arbiter.sv
// ----------------------------------------------------------------------------
// ocsim_source_arbiter
//   Shares one valid/ready output channel between several data sources.
//   Round-robin arbitration with burst locking (up to MaxBurst consecutive
//   beats per requester) and a registered output stage (1-cycle latency,
//   1 beat/cycle throughput). outSource tags every beat with its requester.
//
//   Parameters:
//     Type         payload type per beat
//     Inputs       number of requesters (1..16)
//     MaxBurst     beats granted to one requester before re-arbitration (1..255)
//     SourceWidth  width of the source index
//   Ports:
//     clock      in   single clock
//     reset      in   synchronous, active-high reset
//     inData     in   Type[Inputs] per-requester payload
//     inValid    in   [Inputs] per-requester valid
//     inReady    out  [Inputs] per-requester ready (one-hot or zero)
//     outData    out  registered arbitrated payload
//     outValid   out  registered valid
//     outReady   in   downstream ready
//     outSource  out  requester index that supplied outData
//
//   Optional build macro: OCSIM_SOURCE_ARB_STATS_EN
//     Adds per-requester grant / wait counters, a starvation check that fires
//     `OC_ERROR, and a Report() task. Datapath behaviour is unchanged.
// ----------------------------------------------------------------------------
module ocsim_source_arbiter
    import ocsim_source_arbiter_pkg::*;
#(
    parameter type         Type        = logic [31:0],
    parameter int unsigned Inputs      = 2,
    parameter int unsigned MaxBurst    = 4,
    parameter int unsigned SourceWidth = SourceIndexWidth(Inputs)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  Type                    inData [Inputs],
    input  logic [Inputs-1:0]      inValid,
    output logic [Inputs-1:0]      inReady,
    output Type                    outData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [SourceWidth-1:0] outSource
);

    localparam int unsigned            CountWidth = $clog2(MaxBurst + 1);
    localparam logic [CountWidth-1:0]  MaxCount   = CountWidth'(MaxBurst);
    localparam logic [SourceWidth-1:0] LastIdx    = SourceWidth'(Inputs - 1);

    arb_state_e             r_state;
    logic [SourceWidth-1:0] r_lockIdx;
    logic [CountWidth-1:0]  r_beatCount;
    logic [SourceWidth-1:0] r_rrPointer;
    Type                    r_outData;
    logic                   r_outValid;
    logic [SourceWidth-1:0] r_outSource;

    arb_state_e             w_state_nxt;
    logic [SourceWidth-1:0] w_lockIdx_nxt;
    logic [CountWidth-1:0]  w_beatCount_nxt;
    logic [SourceWidth-1:0] w_rrPointer_nxt;

    logic                   w_space;
    logic                   w_lockHold;
    logic [SourceWidth-1:0] w_releasePtr;
    logic [SourceWidth-1:0] w_pickPtr;
    logic [Inputs-1:0]      w_pickGrant;
    logic [SourceWidth-1:0] w_pickIdx;
    logic                   w_pickAny;
    logic [Inputs-1:0]      w_grantVec;
    logic [SourceWidth-1:0] w_grantIdx;
    logic                   w_accept;

    assign w_space      = !r_outValid || outReady;
    assign w_lockHold   = (r_state == ST_LOCK) && inValid[r_lockIdx] &&
                          (r_beatCount < MaxCount);
    assign w_releasePtr = (r_lockIdx == LastIdx) ? '0 : r_lockIdx + SourceWidth'(1);

    // While locked, the picker already scans from the post-release pointer so
    // a release and the next grant happen in the same cycle without a bubble.
    assign w_pickPtr    = (r_state == ST_LOCK) ? w_releasePtr : r_rrPointer;

    ocsim_rr_pick #(
        .Inputs      (Inputs),
        .SourceWidth (SourceWidth)
    ) u_pick (
        .i_req   (inValid),
        .i_ptr   (w_pickPtr),
        .o_grant (w_pickGrant),
        .o_idx   (w_pickIdx),
        .o_any   (w_pickAny)
    );

    always_comb begin
        w_grantVec      = '0;
        w_grantIdx      = w_pickIdx;
        w_state_nxt     = r_state;
        w_lockIdx_nxt   = r_lockIdx;
        w_beatCount_nxt = r_beatCount;
        w_rrPointer_nxt = r_rrPointer;

        if (w_lockHold) begin
            w_grantVec[r_lockIdx] = 1'b1;
            w_grantIdx            = r_lockIdx;
        end else begin
            w_grantVec = w_pickGrant;
        end

        inReady  = (!reset && w_space) ? w_grantVec : '0;
        w_accept = |(inValid & inReady);

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = ST_LOCK;
                    w_lockIdx_nxt   = w_grantIdx;
                    w_beatCount_nxt = CountWidth'(1);
                end
            end
            ST_LOCK: begin
                if (w_lockHold) begin
                    if (w_accept) begin
                        w_beatCount_nxt = r_beatCount + CountWidth'(1);
                    end
                end else begin
                    w_rrPointer_nxt = w_releasePtr;
                    if (w_accept) begin
                        w_lockIdx_nxt   = w_grantIdx;
                        w_beatCount_nxt = CountWidth'(1);
                    end else begin
                        w_state_nxt     = ST_IDLE;
                        w_beatCount_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_beatCount_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lockIdx   <= '0;
            r_beatCount <= '0;
            r_rrPointer <= '0;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_outSource <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lockIdx   <= w_lockIdx_nxt;
            r_beatCount <= w_beatCount_nxt;
            r_rrPointer <= w_rrPointer_nxt;
            if (w_accept) begin
                r_outData   <= inData[w_grantIdx];
                r_outSource <= w_grantIdx;
                r_outValid  <= 1'b1;
            end else if (outReady) begin
                r_outValid  <= 1'b0;
            end
        end
    end

    assign outData   = r_outData;
    assign outValid  = r_outValid;
    assign outSource = r_outSource;

`ifdef OCSIM_SOURCE_ARB_STATS_EN
`ifndef OC_ERROR
`define OC_ERROR(msg) $error(msg)
`endif

    localparam int unsigned StarveLimit = Inputs * MaxBurst + ArbStarveSlack;

    logic [31:0] r_grantCount [Inputs];
    logic [31:0] r_waitCycles [Inputs];
    logic [31:0] r_starveRun  [Inputs];

    // The starvation run only advances while downstream is accepting; a
    // stalled sink is not the arbiter's fault, so the run is held instead.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned g = 0; g < Inputs; g++) begin
                r_grantCount[g] <= '0;
                r_waitCycles[g] <= '0;
                r_starveRun[g]  <= '0;
            end
        end else begin
            for (int unsigned g = 0; g < Inputs; g++) begin
                if (inValid[g] && inReady[g]) begin
                    r_grantCount[g] <= r_grantCount[g] + 32'd1;
                end
                if (inValid[g] && !inReady[g]) begin
                    r_waitCycles[g] <= r_waitCycles[g] + 32'd1;
                    if (outReady) begin
                        r_starveRun[g] <= r_starveRun[g] + 32'd1;
                    end
                end else begin
                    r_starveRun[g] <= '0;
                end
                if (r_starveRun[g] > 32'(StarveLimit)) begin
                    `OC_ERROR("ocsim_source_arbiter: requester starved");
                end
            end
        end
    end

    task automatic Report();
        for (int unsigned g = 0; g < Inputs; g++) begin
            $display("ocsim_source_arbiter %m source %0d: grants %0d waitCycles %0d",
                     g, r_grantCount[g], r_waitCycles[g]);
        end
    endtask
`endif

endmodule

// File: tb/tb_ocsim_source_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ocsim_source_arbiter
//   Directed bench for ocsim_source_arbiter. dutA: 2 requesters, MaxBurst=4.
//   dutB: 3 requesters, MaxBurst=1. Source payloads encode source and
//   sequence number (base + seq) so beat order per source is checkable.
// ----------------------------------------------------------------------------
module tb_ocsim_source_arbiter;

    logic clk;
    logic rst;

    logic [31:0] a_data [2];
    logic [1:0]  a_valid;
    logic [1:0]  a_ready;
    logic [31:0] a_odata;
    logic        a_ovalid;
    logic        a_oready;
    logic [0:0]  a_osrc;

    logic [31:0] b_data [3];
    logic [2:0]  b_valid;
    logic [2:0]  b_ready;
    logic [31:0] b_odata;
    logic        b_ovalid;
    logic        b_oready;
    logic [1:0]  b_osrc;

    int unsigned a_seq [2];
    int unsigned b_seq [3];
    int unsigned ea_seq [2];
    int unsigned eb_seq [3];

    logic [31:0] a_base [2];
    logic [31:0] b_base [3];

    int n_tests;
    int n_fail;

    ocsim_source_arbiter #(
        .Type     (logic [31:0]),
        .Inputs   (2),
        .MaxBurst (4)
    ) dutA (
        .clock     (clk),
        .reset     (rst),
        .inData    (a_data),
        .inValid   (a_valid),
        .inReady   (a_ready),
        .outData   (a_odata),
        .outValid  (a_ovalid),
        .outReady  (a_oready),
        .outSource (a_osrc)
    );

    ocsim_source_arbiter #(
        .Type     (logic [31:0]),
        .Inputs   (3),
        .MaxBurst (1)
    ) dutB (
        .clock     (clk),
        .reset     (rst),
        .inData    (b_data),
        .inValid   (b_valid),
        .inReady   (b_ready),
        .outData   (b_odata),
        .outValid  (b_ovalid),
        .outReady  (b_oready),
        .outSource (b_osrc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 2; i++) a_data[i] = a_base[i] + a_seq[i];
        for (int i = 0; i < 3; i++) b_data[i] = b_base[i] + b_seq[i];
    endtask

    // Settle, record handshakes, cross the clock edge, then advance the
    // source models so the next payload of each accepting source is presented.
    task automatic tick();
        logic [1:0] acc_a;
        logic [2:0] acc_b;
        #1;
        acc_a = a_valid & a_ready;
        acc_b = b_valid & b_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (acc_a[i]) a_seq[i]++;
        for (int i = 0; i < 3; i++) if (acc_b[i]) b_seq[i]++;
        drive_data();
    endtask

    task automatic check_a_beat(input string tag, input int src);
        check({tag, "_valid"}, 32'(a_ovalid), 32'd1);
        check({tag, "_src"},   32'(a_osrc),   32'(src));
        check({tag, "_data"},  a_odata,       a_base[src] + ea_seq[src]);
        ea_seq[src]++;
    endtask

    task automatic check_b_beat(input string tag, input int src);
        check({tag, "_valid"}, 32'(b_ovalid), 32'd1);
        check({tag, "_src"},   32'(b_osrc),   32'(src));
        check({tag, "_data"},  b_odata,       b_base[src] + eb_seq[src]);
        eb_seq[src]++;
    endtask

    int exp_stream [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    int exp_rr3    [7]  = '{0, 1, 2, 0, 1, 2, 0};
    logic [31:0] held;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        a_base[0] = 32'hA000_0000;
        a_base[1] = 32'hB000_0000;
        b_base[0] = 32'hC000_0000;
        b_base[1] = 32'hD000_0000;
        b_base[2] = 32'hE000_0000;
        for (int i = 0; i < 2; i++) begin a_seq[i] = 0; ea_seq[i] = 0; end
        for (int i = 0; i < 3; i++) begin b_seq[i] = 0; eb_seq[i] = 0; end

        // Reset held with requests pending: nothing may be granted.
        rst      = 1'b1;
        a_valid  = 2'b11;
        b_valid  = 3'b000;
        a_oready = 1'b1;
        b_oready = 1'b1;
        drive_data();
        repeat (3) @(posedge clk);
        #1;
        check("rst_inready", 32'(a_ready),  32'd0);
        check("rst_ovalid",  32'(a_ovalid), 32'd0);
        check("rst_osrc",    32'(a_osrc),   32'd0);
        check("rst_odata",   a_odata,       32'd0);

        // Release with no requests: idle for 10 cycles.
        a_valid = 2'b00;
        rst     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_ovalid",  32'(a_ovalid), 32'd0);
            check("idle_inready", 32'(a_ready),  32'd0);
            check("idle_osrc",    32'(a_osrc),   32'd0);
        end

        // Both sources streaming: bursts of 4 alternate, 1 beat per cycle.
        a_valid = 2'b11;
        for (int k = 0; k < 14; k++) begin
            tick();
            check_a_beat("stream", exp_stream[k]);
        end

        // Reset mid-burst (source 1 holds the lock, outValid=1).
        rst = 1'b1;
        tick();
        check("midrst_ovalid", 32'(a_ovalid), 32'd0);
        check("midrst_osrc",   32'(a_osrc),   32'd0);
        check("midrst_odata",  a_odata,       32'd0);
`ifdef OCSIM_SOURCE_ARB_STATS_EN
        check("midrst_grantcnt0", dutA.r_grantCount[0], 32'd0);
        check("midrst_grantcnt1", dutA.r_grantCount[1], 32'd0);
`endif
        rst = 1'b0;

        // First post-reset grant goes to source 0; two beats, then source 0
        // drops valid and source 1 takes over with no bubble.
        tick();
        check_a_beat("postrst", 0);
        tick();
        check_a_beat("src0_b2", 0);
        a_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_a_beat("handover", 1);
        end

        // Stall mid-burst at beatCount=2: output holds, no ready asserted,
        // burst resumes for exactly two more beats.
        rst     = 1'b1;
        a_valid = 2'b11;
        tick();
        rst = 1'b0;
        tick();
        check_a_beat("stall_pre1", 0);
        tick();
        check_a_beat("stall_pre2", 0);
        held     = a_base[0] + ea_seq[0] - 32'd1;
        a_oready = 1'b0;
        #1;
        check("stall_inready0", 32'(a_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_ovalid",  32'(a_ovalid), 32'd1);
            check("stall_odata",   a_odata,       held);
            check("stall_osrc",    32'(a_osrc),   32'd0);
            check("stall_inready", 32'(a_ready),  32'd0);
        end
        a_oready = 1'b1;
        tick();
        check_a_beat("resume_b3", 0);
        tick();
        check_a_beat("resume_b4", 0);
        tick();
        check_a_beat("resume_rel", 1);

        // Three requesters, MaxBurst=1: strict rotation, pointer wraps 2->0.
        a_valid = 2'b00;
        b_valid = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_b_beat("rr3", exp_rr3[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ocsim_source_arbiter.md
Name: ocsim_source_arbiter

Overview:
- Shares one valid/ready output channel between Inputs data-source transactors (e.g. several ocsim_data_source instances feeding one DUT port).
- Round-robin arbitration with burst locking, plus a registered output stage.
- Reports which source supplied each beat so scoreboards can route expected data.
- Synthesizable RTL; used in sim benches and reusable as a lightweight mux in FPGA test harnesses.

Parameters:
- Type, logic [31:0], payload type carried per beat
- Inputs, 2, number of requesters (1..16)
- MaxBurst, 4, max consecutive beats granted to one requester before re-arbitration (1..255)
- SourceWidth, ((Inputs>1) ? $clog2(Inputs) : 1), width of source index

Ports:
- clock  input  1  single clock
- reset  input  1  synchronous, active-high reset
- inData  input  Type[Inputs]  per-requester payload
- inValid  input  [Inputs]  per-requester valid
- inReady  output  [Inputs]  per-requester ready
- outData  output  Type  arbitrated payload (registered)
- outValid  output  1  registered valid
- outReady  input  1  downstream ready
- outSource  output  SourceWidth  index of the requester that supplied the current outData

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high, sampled on posedge clock. Reset mid-operation drops any in-flight beat.
  - Reset values: outValid=0, outData='0, outSource=0, rrPointer=0, state=IDLE, beatCount=0.
  - inReady=0 while reset is high.
- Output stage:
  - Define space = !outValid || outReady.
  - A beat is accepted from input g when inValid[g] && inReady[g].
  - On acceptance, outData/outSource/outValid update on the next posedge: 1-cycle latency.
  - outValid clears on outReady with no new accept. Full throughput: 1 beat/cycle when outReady=1.
- Grant (combinational each cycle):
  - In LOCK with inValid[lockIdx] && beatCount<MaxBurst: grant lockIdx.
  - Otherwise grant the first asserting inValid scanning rrPointer, rrPointer+1, ... modulo Inputs.
- inReady is one-hot on the grant, and only when space=1 and reset=0. At most one inReady is high per cycle.
- State machine:
  - IDLE --accept from g--> LOCK: lockIdx=g, beatCount=1.
  - LOCK --accept from lockIdx with beatCount<MaxBurst--> LOCK: beatCount++.
  - LOCK --lockIdx deasserts inValid, or beatCount==MaxBurst--> release. Re-arbitration happens in the same cycle, so there is no bubble; an accept in that cycle re-enters LOCK with beatCount=1.
  - LOCK with no accept and no valid anywhere --> IDLE.
- Round-robin pointer: on each release, rrPointer = lockIdx+1 modulo Inputs (wraps Inputs-1 -> 0).
- Boundary conditions:
  - MaxBurst=1 gives pure per-beat round-robin.
  - Inputs=1: grant is always 0, arbiter degenerates to a register slice.
  - outReady=0 stalls: no inReady asserted, beatCount and lock held.
  - Requester raises valid while another holds the lock: waits until release, bounded by MaxBurst beats.
  - beatCount is saturating, width $clog2(MaxBurst+1).

Optional Feature:
- Macro: OCSIM_SOURCE_ARB_STATS_EN
- When defined:
  - Per-requester 32-bit grantCount (wraps) and waitCycles counters, cleared on reset.
  - Starvation check: any requester valid-but-not-granted for more than Inputs*MaxBurst+2 consecutive cycles with outReady=1 fires `OC_ERROR.
  - Task Report() prints the counts via $display.
- When undefined: no counters, no check, no task; datapath behaviour identical.

Decomposition:
- ocsim_pkg additions:
  - function SourceIndexWidth(Inputs)
  - localparam ArbStarveSlack=2
- Sub-module ocsim_rr_pick: purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable by future sink arbiters.
- Top holds the state register, burst counter, pointer and output register.

Test Plan:
- Reset release, Inputs=2, all inValid=0 -> outValid=0, inReady=00, outSource=0 for 10 cycles.
- Both sources streaming, MaxBurst=4, outReady=1 -> outSource sequence 0,0,0,0,1,1,1,1,0..., 1 beat/cycle, data order preserved per source.
- Source 0 sends 2 beats then drops valid while source 1 is valid -> grant moves to 1 in the same cycle, no bubble cycle on outValid.
- outReady held 0 for 5 cycles mid-burst (beatCount=2) -> outData stable, inReady=0, burst resumes with beatCount=3 afterwards.
- Inputs=3, MaxBurst=1, all valid -> outSource 0,1,2,0,1,2; pointer wraps 2->0.
- Synchronous reset asserted mid-burst with outValid=1 -> next cycle outValid=0, first post-reset grant goes to source 0; with OCSIM_SOURCE_ARB_STATS_EN, grantCount reads 0.
